// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // An access is rejected without touching the bus if its width/sign code is
  // unknown, is a load-only code used for a store, is misaligned for its size,
  // or asks for a load and a store at once.
  function automatic logic access_fault(input logic       we,
                                        input logic       re,
                                        input logic [2:0] op,
                                        input logic [1:0] addr_lo);
    logic f;
    f = we & re;
    case (op)
      F3_B:    f = f;
      F3_BU:   f = f | we;
      F3_H:    f = f | addr_lo[0];
      F3_HU:   f = f | addr_lo[0] | we;
      F3_W:    f = f | (addr_lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane formatting: store replication / strobes and load shift / extend.
import mem_pkg::*;

module mem_lane_align (
  input  logic [2:0]        op,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       st_data,
  input  logic [31:0]       ld_rdata,
  output logic [31:0]       st_wdata,
  output logic [STRB_W-1:0] st_wstrb,
  output logic [31:0]       ld_data
);

  logic [31:0] ld_shift;

  assign ld_shift = ld_rdata >> {addr_lo, 3'b000};

  // Replicate store data across every lane it could land in; strobes pick the lane.
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (op[1:0])
      2'b00: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << addr_lo;
      end
      2'b01: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0 and extend to the full word.
  always_comb begin
    case (op)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   ld_data = {24'h000000, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   ld_data = {16'h0000, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory responder: one outstanding req/ack access at a time.
//
//   state | meaning
//   IDLE  | waiting for an access from EX/MEM; faults are flagged here
//   REQ   | dbus_req held with captured address/data until ack or timeout
//   DONE  | pipeline released; load_valid or timeout error pulses
import mem_pkg::*;

module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            opm,
  input  logic                  mem_wem,
  input  logic                  mem_rem,
  input  logic [ADDR_WIDTH-1:0] alu_resultm,
  input  logic [DATA_WIDTH-1:0] rd2_turem,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [ADDR_WIDTH-1:0] dbus_addr,
  output logic [STRB_W-1:0]     dbus_wstrb,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [DATA_WIDTH-1:0] dbus_rdata,
  output logic                  mem_stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  mem_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              lo_q, lo_d;
  logic [2:0]              op_q, op_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
  logic                    load_valid_q, load_valid_d;
  logic                    tmo_err_q, tmo_err_d;

  logic                    fault_now;
  logic                    stall_now;
  logic [2:0]              al_op;
  logic [1:0]              al_lo;
  logic [31:0]             al_wdata;
  logic [31:0]             al_ld;
  logic [STRB_W-1:0]       al_wstrb;

  // In IDLE the aligner formats the incoming store; afterwards it decodes the
  // read word using the captured size and offset.
  assign al_op = (state_q == IDLE) ? opm : op_q;
  assign al_lo = (state_q == IDLE) ? alu_resultm[1:0] : lo_q;

  mem_lane_align u_align (
    .op       (al_op),
    .addr_lo  (al_lo),
    .st_data  (rd2_turem),
    .ld_rdata (dbus_rdata),
    .st_wdata (al_wdata),
    .st_wstrb (al_wstrb),
    .ld_data  (al_ld)
  );

  // Next-state and capture logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    lo_d         = lo_q;
    op_d         = op_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    tmo_err_d    = 1'b0;
    fault_now    = 1'b0;
    stall_now    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_wem || mem_rem) begin
          if (access_fault(mem_wem, mem_rem, opm, alu_resultm[1:0])) begin
            fault_now = 1'b1;
          end else begin
            stall_now = 1'b1;
            state_d   = REQ;
            req_d     = 1'b1;
            we_d      = mem_wem;
            addr_d    = {alu_resultm[ADDR_WIDTH-1:2], 2'b00};
            lo_d      = alu_resultm[1:0];
            op_d      = opm;
            wstrb_d   = al_wstrb;
            wdata_d   = DATA_WIDTH'(al_wdata);
            cnt_d     = '0;
          end
        end
      end
      REQ: begin
        stall_now = 1'b1;
        if (dbus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            load_data_d  = DATA_WIDTH'(al_ld);
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          req_d     = 1'b0;
          tmo_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      lo_q         <= 2'b00;
      op_q         <= 3'b000;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      lo_q         <= lo_d;
      op_q         <= op_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_wstrb = wstrb_q;
  assign dbus_wdata = wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  // The IDLE-cycle stall and fault pulse are combinational, so mask them
  // while reset is held to keep every output quiet.
  assign mem_stall  = stall_now & ~rst;
  assign mem_err    = (fault_now & ~rst) | tmo_err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory responder in the 5-stage RV32 core. It consumes the EX/MEM pipeline register outputs (funct3, load/store strobes, ALU address, store data) and issues the access on a single-outstanding req/ack data bus. It stalls the pipeline while the access is pending and returns aligned, sign- or zero-extended load data to writeback.

Parameters:
DATA_WIDTH, 32, data path width (only 32 supported)
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 255, maximum REQ-state cycles before abort with bus error (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
opm  input  3  funct3 from EX/MEM: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_wem  input  1  store request
mem_rem  input  1  load request
alu_resultm  input  ADDR_WIDTH  byte address
rd2_turem  input  DATA_WIDTH  store data, unaligned (LSBs)
dbus_req  output  1  bus request, held until ack
dbus_we  output  1  1 = write
dbus_addr  output  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
dbus_wstrb  output  4  byte-lane strobes
dbus_wdata  output  DATA_WIDTH  lane-replicated store data
dbus_ack  input  1  access complete; rdata valid same cycle for reads
dbus_rdata  input  DATA_WIDTH  read word
mem_stall  output  1  hold IF..EX/MEM registers
load_data  output  DATA_WIDTH  extended load result, registered
load_valid  output  1  1-cycle pulse, load_data updated
mem_err  output  1  1-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset (async): state IDLE; dbus_req, dbus_we, dbus_wstrb, mem_stall, load_valid, mem_err, load_data, timeout counter all 0.
- States: IDLE, REQ, DONE.
- IDLE, with a legal, aligned access pending (exactly one of mem_wem/mem_rem set): capture addr, opm, we, and the formatted wdata/wstrb; go to REQ. mem_stall is 1 combinationally in this cycle.
- IDLE, with no access pending: mem_stall 0; any dbus_ack is ignored.
- REQ: dbus_req = 1, with the captured outputs held stable. mem_stall = 1. Counter increments each cycle.
  - On dbus_ack: for a load, register the extracted and extended data; go to DONE.
  - If counter reaches TIMEOUT_CYCLES without ack: drop req and go to DONE with the error flag set.
- DONE: mem_stall = 0, so the pipeline advances at this edge.
  - load_valid = 1 for a successful load.
  - mem_err = 1 if the access timed out.
  - Next state is IDLE; the counter clears.
- Latency: with ack in the first REQ cycle, an access occupies 3 cycles and stalls for 2 of them. Each additional wait cycle adds 1.
- Ack in the same cycle req first rises is legal.
- Alignment faults get no bus access and no stall. mem_err pulses for the cycle the access is present in IDLE, which then treats the access as consumed. Faults are:
  - H/HU with addr[0] = 1
  - W with addr[1:0] != 0
  - funct3 011, 110 or 111
  - funct3 100 or 101 on a store
  - mem_wem and mem_rem both set
- Store formatting:
  - SB: wdata = {4{d[7:0]}}, wstrb = 0001 << addr[1:0]
  - SH: wdata = {2{d[15:0]}}, wstrb = 0011 << (2*addr[1])
  - SW: wdata = d, wstrb = 1111
- Load extraction: shift rdata right by 8*addr[1:0]. Then:
  - B: sign-extend bits [7:0]
  - BU: zero-extend bits [7:0]
  - H: sign-extend bits [15:0]
  - HU: zero-extend bits [15:0]
  - W: pass through
- load_data holds its value until the next successful load.
- Reset mid-REQ drops dbus_req immediately, and no completion is reported. The external bus must tolerate an abandoned request.

Decomposition:
- Shared package mem_pkg holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state encoding (IDLE/REQ/DONE)
  - the strobe width constant
- One combinational sub-module, mem_lane_align, provides store replication/strobe generation and load shift/extend. It is instantiated once and shared by the capture and completion paths.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ack on 1st REQ cycle -> req 1 cycle, we=1, wstrb 1111, dbus_addr 0x100, stall high 2 cycles, no err.
- LB addr 0x203, rdata 0x80FF_0000 -> load_data 0xFFFF_FF80, load_valid 1 pulse; LBU at same addr -> 0x0000_0080.
- SH addr 0x42, data 0x1234ABCD -> wdata 0xABCDABCD, wstrb 1100, dbus_addr 0x40.
- LW addr 0x101 -> mem_err pulse, dbus_req never rises, mem_stall 0.
- LH addr 0x10, ack delayed 5 cycles, rdata 0x0000_8001 -> stall 7 cycles, load_data 0xFFFF_8001; ack in IDLE beforehand ignored.
- TIMEOUT_CYCLES=4, no ack -> req for 4 cycles, then DONE with mem_err pulse, load_valid 0. Separately, assert rst in REQ -> req/stall drop immediately, state IDLE.
